// File: rtl/game_pkg.sv
// game_pkg: shared enums for the game core and its step counter
package game_pkg;
    typedef enum logic [1:0] {
        CTRL_UP_LO = 2'b00,
        CTRL_UP_HI = 2'b01,
        CTRL_DN_LO = 2'b10,
        CTRL_DN_HI = 2'b11
    } ctrl_e;
    typedef enum logic [1:0] {
        WHO_NONE   = 2'b00,
        WHO_LOSER  = 2'b01,
        WHO_WINNER = 2'b10
    } who_e;
    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_e;
endpackage

// File: rtl/game_step_counter.sv
// game_step_counter: wrapping up/down step counter with load and all-ones/zero flags
module game_step_counter
    import game_pkg::*;
#(
    parameter int SIZE    = 4,
    parameter int STEP_LO = 1,
    parameter int STEP_HI = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    input  logic            load,
    input  logic [SIZE-1:0] init_value,
    input  logic [1:0]      control,
    output logic [SIZE-1:0] count,
    output logic            winner,
    output logic            loser
);
    ctrl_e           mode;
    logic [SIZE-1:0] step;
    logic [SIZE-1:0] count_next;
    assign mode = ctrl_e'(control);
    // next count: load wins over stepping; arithmetic wraps modulo 2**SIZE
    always_comb begin
        step       = (mode == CTRL_UP_HI || mode == CTRL_DN_HI) ? SIZE'(STEP_HI) : SIZE'(STEP_LO);
        count_next = load ? init_value :
                     (mode == CTRL_DN_LO || mode == CTRL_DN_HI) ? count - step : count + step;
    end
    // flags describe only the value written on this edge; idle edges clear them
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count  <= '0;
            winner <= 1'b0;
            loser  <= 1'b0;
        end else if (enable) begin
            count  <= count_next;
            winner <= &count_next;
            loser  <= ~|count_next;
        end else begin
            winner <= 1'b0;
            loser  <= 1'b0;
        end
    end
endmodule

// File: rtl/game_core_p.sv
// game_core_p: step counter, score keeping and game-over arbiter with restart handshake
module game_core_p
    import game_pkg::*;
#(
    parameter int SIZE      = 4,
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 2**SCORE_W - 1,
    parameter int STEP_LO   = 1,
    parameter int STEP_HI   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         control,
    input  logic               init_load,
    input  logic [SIZE-1:0]    init_value,
    input  logic               restart,
    output logic [SIZE-1:0]    count,
    output logic               winner,
    output logic               loser,
    output logic [SCORE_W-1:0] w_count,
    output logic [SCORE_W-1:0] l_count,
    output logic               gameover,
    output logic [1:0]         who
);
    if (SIZE < 2) begin : g_bad_size
        $error("game_core_p: SIZE must be at least 2");
    end
    if (WIN_SCORE < 1 || WIN_SCORE >= 2**SCORE_W) begin : g_bad_win
        $error("game_core_p: WIN_SCORE out of range");
    end
    if (STEP_LO < 1 || STEP_LO >= 2**SIZE || STEP_HI < 1 || STEP_HI >= 2**SIZE) begin : g_bad_step
        $error("game_core_p: step size out of range");
    end

    localparam logic [SCORE_W:0] WIN = (SCORE_W+1)'(WIN_SCORE);

    state_e state;
    who_e   who_q;
    logic   end_next;
    logic   enable;
    logic   clear;
    assign who = who_q;

    // one extra score bit keeps the +1 compare exact when WIN_SCORE is the max code
    always_comb begin
        end_next = (state == PLAY) &&
                   ((winner && ({1'b0, w_count} + (SCORE_W+1)'(1)) == WIN) ||
                    (loser  && ({1'b0, l_count} + (SCORE_W+1)'(1)) == WIN));
        enable   = (state == PLAY) && !end_next;
        clear    = (state == OVER) && restart;
    end

    game_step_counter #(
        .SIZE    (SIZE),
        .STEP_LO (STEP_LO),
        .STEP_HI (STEP_HI)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .enable     (enable),
        .load       (init_load),
        .init_value (init_value),
        .control    (control),
        .count      (count),
        .winner     (winner),
        .loser      (loser)
    );

    // scores saturate; the deciding increment lands on the same edge as gameover
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state    <= PLAY;
            w_count  <= '0;
            l_count  <= '0;
            gameover <= 1'b0;
            who_q    <= WHO_NONE;
        end else if (state == PLAY) begin
            if (winner && {1'b0, w_count} < WIN)
                w_count <= w_count + SCORE_W'(1);
            if (loser && {1'b0, l_count} < WIN)
                l_count <= l_count + SCORE_W'(1);
            if (end_next) begin
                state    <= OVER;
                gameover <= 1'b1;
                who_q    <= winner ? WHO_WINNER : WHO_LOSER;
            end
        end
    end
endmodule

// File: tb/tb_game_core_p.sv
// tb_game_core_p: randomized and directed checks of two game_core_p configurations against a game-rule model
module tb_game_core_p;
    logic       clk = 1'b0;
    logic       reset, init_load, restart;
    logic [1:0] control;
    logic [3:0] init_value;

    logic [3:0] count_a, w_a, l_a;
    logic       winner_a, loser_a, gameover_a;
    logic [1:0] who_a;
    logic [2:0] count_b;
    logic [3:0] w_b, l_b;
    logic       winner_b, loser_b, gameover_b;
    logic [1:0] who_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_core_p #(.SIZE(4), .SCORE_W(4), .WIN_SCORE(5), .STEP_LO(1), .STEP_HI(2)) dut_a (
        .clk(clk), .reset(reset), .control(control), .init_load(init_load),
        .init_value(init_value), .restart(restart), .count(count_a), .winner(winner_a),
        .loser(loser_a), .w_count(w_a), .l_count(l_a), .gameover(gameover_a), .who(who_a)
    );

    game_core_p #(.SIZE(3), .SCORE_W(4), .WIN_SCORE(2), .STEP_LO(1), .STEP_HI(3)) dut_b (
        .clk(clk), .reset(reset), .control(control), .init_load(init_load),
        .init_value(init_value[2:0]), .restart(restart), .count(count_b), .winner(winner_b),
        .loser(loser_b), .w_count(w_b), .l_count(l_b), .gameover(gameover_b), .who(who_b)
    );

    function automatic int sz(input int k); return k == 0 ? 4 : 3; endfunction
    function automatic int ws(input int k); return k == 0 ? 5 : 2; endfunction
    function automatic int hi(input int k); return k == 0 ? 2 : 3; endfunction

    typedef struct {
        int count, w, l, win, los, over, who;
    } mdl_t;
    mdl_t m[2];

    // game rules applied to one configuration for one clock edge
    task automatic mstep(input int k);
        int mx, st, nc;
        bit ending;
        mx = (1 << sz(k)) - 1;
        if (reset || (m[k].over != 0 && restart)) begin
            m[k] = '{0, 0, 0, 0, 0, 0, 0};
        end else if (m[k].over == 0) begin
            ending = (m[k].win != 0 && m[k].w + 1 == ws(k)) || (m[k].los != 0 && m[k].l + 1 == ws(k));
            if (m[k].win != 0 && m[k].w < ws(k)) m[k].w++;
            if (m[k].los != 0 && m[k].l < ws(k)) m[k].l++;
            if (ending) begin
                m[k].over = 1;
                m[k].who  = m[k].win != 0 ? 2 : 1;
                m[k].win  = 0;
                m[k].los  = 0;
            end else begin
                st = control[0] ? hi(k) : 1;
                nc = init_load ? (int'(init_value) & mx) : ((control[1] ? m[k].count - st : m[k].count + st) & mx);
                m[k].count = nc;
                m[k].win   = (nc == mx) ? 1 : 0;
                m[k].los   = (nc == 0) ? 1 : 0;
            end
        end
    endtask

    function automatic logic [31:0] pk(input logic [7:0] c, input logic wi, input logic lo,
                                       input logic [7:0] w, input logic [7:0] l,
                                       input logic go, input logic [1:0] wh);
        return {3'b0, c, wi, lo, w, l, go, wh};
    endfunction

    function automatic logic [31:0] obs(input int k);
        return k == 0 ? pk(8'(count_a), winner_a, loser_a, 8'(w_a), 8'(l_a), gameover_a, who_a)
                      : pk(8'(count_b), winner_b, loser_b, 8'(w_b), 8'(l_b), gameover_b, who_b);
    endfunction

    function automatic logic [31:0] expm(input int k);
        return pk(8'(m[k].count), m[k].win != 0, m[k].los != 0, 8'(m[k].w), 8'(m[k].l),
                  m[k].over != 0, 2'(m[k].who));
    endfunction

    task automatic tick();
        @(posedge clk);
        mstep(0);
        mstep(1);
        #1;
    endtask

    task automatic idle();
        reset = 0; init_load = 0; restart = 0; control = 2'b00; init_value = 4'd0;
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== 32'd0) begin
                errors++;
                $display("FAIL reset dut%0d: got %h want 00000000", k, obs(k));
            end
        end
        idle();
    endtask

    task automatic test_count_up();
        reset = 1; tick(); idle();
        repeat (15) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expm(k)) begin
                    errors++;
                    $display("FAIL count_up dut%0d: got %h want %h", k, obs(k), expm(k));
                end
            end
        end
        checks++;
        if (count_a !== 4'd15 || winner_a !== 1'b1) begin
            errors++;
            $display("FAIL count_up_15: got count=%0d winner=%b want count=15 winner=1", count_a, winner_a);
        end
        tick();
        checks++;
        if (w_a !== 4'd1) begin
            errors++;
            $display("FAIL count_up_score: got w_count=%0d want 1", w_a);
        end
    endtask

    task automatic test_load_wrap();
        reset = 1; tick(); idle();
        init_load = 1; init_value = 4'd14;
        tick();
        checks++;
        if (count_a !== 4'd14) begin
            errors++;
            $display("FAIL load: got count=%0d want 14", count_a);
        end
        init_load = 0; control = 2'b01;
        tick();
        checks++;
        if (count_a !== 4'd0 || loser_a !== 1'b1 || winner_a !== 1'b0) begin
            errors++;
            $display("FAIL wrap_up: got count=%0d loser=%b winner=%b want 0 1 0", count_a, loser_a, winner_a);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expm(k)) begin
                errors++;
                $display("FAIL load_wrap dut%0d: got %h want %h", k, obs(k), expm(k));
            end
        end
        checks++;
        if (l_a !== 4'd1) begin
            errors++;
            $display("FAIL wrap_score: got l_count=%0d want 1", l_a);
        end
    endtask

    task automatic test_gameover();
        logic [1:0] ctl[5] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10};
        logic       ld[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        reset = 1; tick(); idle();
        init_value = 4'd1;
        for (int i = 0; i < 6; i++) begin
            init_load = i < 5 ? ld[i] : 1'b0;
            control   = i < 5 ? ctl[i] : 2'b10;
            tick();
            checks++;
            if (obs(1) !== expm(1)) begin
                errors++;
                $display("FAIL gameover_seq step%0d: got %h want %h", i, obs(1), expm(1));
            end
        end
        checks++;
        if (gameover_b !== 1'b1 || who_b !== 2'b01 || l_b !== 4'd2) begin
            errors++;
            $display("FAIL gameover: got go=%b who=%b l=%0d want 1 01 2", gameover_b, who_b, l_b);
        end
        init_load = 1; init_value = 4'd5; control = 2'b01;
        repeat (3) tick();
        checks++;
        if (count_b !== 3'd0 || gameover_b !== 1'b1 || who_b !== 2'b01 || l_b !== 4'd2) begin
            errors++;
            $display("FAIL over_hold: got count=%0d go=%b who=%b l=%0d want 0 1 01 2", count_b, gameover_b, who_b, l_b);
        end
        idle();
    endtask

    task automatic test_restart();
        restart = 1;
        tick();
        checks++;
        if (obs(1) !== 32'd0) begin
            errors++;
            $display("FAIL restart: got %h want 00000000", obs(1));
        end
        restart = 0; control = 2'b00;
        tick();
        restart = 1;
        tick();
        restart = 0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expm(k)) begin
                errors++;
                $display("FAIL restart_in_play dut%0d: got %h want %h", k, obs(k), expm(k));
            end
        end
        checks++;
        if (count_b !== 3'd2 || gameover_b !== 1'b0) begin
            errors++;
            $display("FAIL restart_in_play_b: got count=%0d go=%b want 2 0", count_b, gameover_b);
        end
    endtask

    task automatic test_reset_midgame();
        reset = 1; tick(); idle();
        init_load = 1; init_value = 4'd15;
        repeat (3) tick();
        init_load = 0; control = 2'b10;
        tick();
        checks++;
        if (w_a !== 4'd3 || gameover_a !== 1'b0) begin
            errors++;
            $display("FAIL midgame_score: got w_count=%0d go=%b want 3 0", w_a, gameover_a);
        end
        reset = 1; init_load = 1; restart = 1;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== 32'd0) begin
                errors++;
                $display("FAIL reset_midgame dut%0d: got %h want 00000000", k, obs(k));
            end
        end
        idle();
    endtask

    task automatic test_wrap_hi();
        reset = 1; tick(); idle();
        init_load = 1; init_value = 4'd6;
        tick();
        init_load = 0; control = 2'b01;
        tick();
        checks++;
        if (count_b !== 3'd1 || winner_b !== 1'b0 || loser_b !== 1'b0) begin
            errors++;
            $display("FAIL wrap_hi: got count=%0d winner=%b loser=%b want 1 0 0", count_b, winner_b, loser_b);
        end
        idle();
    endtask

    task automatic test_random();
        reset = 1; tick();
        repeat (600) begin
            reset      = $urandom_range(0, 99) == 0;
            restart    = $urandom_range(0, 7) == 0;
            init_load  = $urandom_range(0, 5) == 0;
            control    = 2'($urandom_range(0, 3));
            init_value = 4'($urandom_range(0, 15));
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expm(k)) begin
                    errors++;
                    $display("FAIL random dut%0d: got %h want %h", k, obs(k), expm(k));
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_count_up();
        test_load_wrap();
        test_gameover();
        test_restart();
        test_reset_midgame();
        test_wrap_hi();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
